// File: rtl/atomrv_lsu_pkg.sv
// Shared types and funct3 decode helpers for the atomrv load/store unit.
package atomrv_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Unlisted encodings fall through to a word access.
    function automatic lsu_size_t load_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic lsu_size_t store_size(input logic [2:0] f3);
        case (f3)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic load_is_signed(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH);
    endfunction

endpackage

// File: rtl/atomrv_lsu_if.sv
// Execute/DCCM/writeback bundle of the LSU; slave is the LSU, master is its environment.
interface atomrv_lsu_if #(
    parameter int unsigned DATAWIDTH        = 32,
    parameter int unsigned REG_ADRESS_WIDTH = 5
);
    logic                        ex_valid_i;
    logic                        ready_o;
    logic                        ex_load_i;
    logic                        ex_store_i;
    logic [2:0]                  ex_funct3_i;
    logic [DATAWIDTH-1:0]        ex_alu_i;
    logic [DATAWIDTH-1:0]        ex_sdata_i;
    logic                        ex_rwr_en_i;
    logic [REG_ADRESS_WIDTH-1:0] ex_rd_i;
    logic [DATAWIDTH-1:0]        dccm_addr_o;
    logic                        dccm_rd_en_o;
    logic                        dccm_wr_en_o;
    logic [DATAWIDTH-1:0]        dccm_wdata_o;
    logic [DATAWIDTH-1:0]        dccm_rdata_i;
    logic                        wb_rwr_en_o;
    logic [REG_ADRESS_WIDTH-1:0] wb_rd_o;
    logic [DATAWIDTH-1:0]        wb_data_o;
    logic                        misalign_o;

    modport slave (
        input  ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_alu_i, ex_sdata_i,
               ex_rwr_en_i, ex_rd_i, dccm_rdata_i,
        output ready_o, dccm_addr_o, dccm_rd_en_o, dccm_wr_en_o, dccm_wdata_o,
               wb_rwr_en_o, wb_rd_o, wb_data_o, misalign_o
    );

    modport master (
        output ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_alu_i, ex_sdata_i,
               ex_rwr_en_i, ex_rd_i, dccm_rdata_i,
        input  ready_o, dccm_addr_o, dccm_rd_en_o, dccm_wr_en_o, dccm_wdata_o,
               wb_rwr_en_o, wb_rd_o, wb_data_o, misalign_o
    );
endinterface

// File: rtl/atomrv_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into the read word.
module atomrv_lsu_align
    import atomrv_lsu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] rdata,
    input  logic [DATAWIDTH-1:0] sdata,
    input  logic [1:0]           offset,
    input  lsu_size_t            size,
    input  logic                 sign_ext,
    output logic [DATAWIDTH-1:0] load_data,
    output logic [DATAWIDTH-1:0] merge_data
);
    logic [4:0]           shamt;
    logic [DATAWIDTH-1:0] lane;
    logic [DATAWIDTH-1:0] byte_mask;
    logic [DATAWIDTH-1:0] half_mask;
    logic [DATAWIDTH-1:0] byte_ins;
    logic [DATAWIDTH-1:0] half_ins;

    assign shamt     = {offset, 3'b000};
    assign byte_mask = {{(DATAWIDTH-8){1'b0}}, 8'hFF} << shamt;
    assign half_mask = {{(DATAWIDTH-16){1'b0}}, 16'hFFFF} << shamt;
    assign byte_ins  = {{(DATAWIDTH-8){1'b0}}, sdata[7:0]} << shamt;
    assign half_ins  = {{(DATAWIDTH-16){1'b0}}, sdata[15:0]} << shamt;

    always_comb begin
        lane       = rdata >> shamt;
        load_data  = rdata;
        merge_data = sdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{(DATAWIDTH-8){sign_ext & lane[7]}}, lane[7:0]};
                merge_data = (rdata & ~byte_mask) | byte_ins;
            end
            SZ_HALF: begin
                load_data  = {{(DATAWIDTH-16){sign_ext & lane[15]}}, lane[15:0]};
                merge_data = (rdata & ~half_mask) | half_ins;
            end
            default: begin
                load_data  = rdata;
                merge_data = sdata;
            end
        endcase
    end
endmodule

// File: rtl/atomrv_lsu.sv
// atomrv_lsu: memory-stage LSU with read-modify-write for SB/SH on a byte-enable-less DCCM.
// Optional ATOMRV_LSU_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of aligning them.
module atomrv_lsu
    import atomrv_lsu_pkg::*;
#(
    parameter int unsigned DATAWIDTH        = 32,
    parameter int unsigned ADDRESS_BUS      = 10,
    parameter int unsigned REG_ADRESS_WIDTH = 5
) (
    input logic         clk_i,
    input logic         rst_ni,
    atomrv_lsu_if.slave bus
);
    lsu_state_t                  state_q;
    logic [DATAWIDTH-1:0]        merge_q;
    logic [ADDRESS_BUS-1:0]      waddr_q;
    logic                        wb_rwr_en_q;
    logic [REG_ADRESS_WIDTH-1:0] wb_rd_q;
    logic [DATAWIDTH-1:0]        wb_data_q;

    logic [ADDRESS_BUS-1:0]      ex_widx;
    logic [ADDRESS_BUS-1:0]      acc_widx;
    lsu_size_t                   size;
    logic [1:0]                  offset;
    logic                        accept;
    logic                        mem_op;
    logic                        misaligned;
    logic                        access;
    logic                        sub_store;
    logic                        rd_en;
    logic                        wr_en;
    logic [DATAWIDTH-1:0]        wdata;
    logic [DATAWIDTH-1:0]        load_data;
    logic [DATAWIDTH-1:0]        merge_data;
    logic                        unused_hi;

    assign unused_hi = ^bus.ex_alu_i[DATAWIDTH-1:ADDRESS_BUS+2];

    assign accept    = bus.ex_valid_i && (state_q == IDLE);
    assign mem_op    = bus.ex_load_i || bus.ex_store_i;
    assign size      = bus.ex_store_i ? store_size(bus.ex_funct3_i) : load_size(bus.ex_funct3_i);
    assign ex_widx   = bus.ex_alu_i[ADDRESS_BUS+1:2];
    assign sub_store = bus.ex_store_i && (size != SZ_WORD);

    // Lane offset forced to natural alignment; misaligned cases are either trapped or silently aligned.
    always_comb begin
        case (size)
            SZ_BYTE: offset = bus.ex_alu_i[1:0];
            SZ_HALF: offset = {bus.ex_alu_i[1], 1'b0};
            default: offset = 2'b00;
        endcase
    end

`ifdef ATOMRV_LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned = mem_op &&
                        (((size == SZ_HALF) && bus.ex_alu_i[0]) ||
                         ((size == SZ_WORD) && (bus.ex_alu_i[1:0] != 2'b00)));
    assign bus.misalign_o = misalign_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) misalign_q <= 1'b0;
        else         misalign_q <= accept && misaligned;
    end
`else
    assign misaligned     = 1'b0;
    assign bus.misalign_o = 1'b0;
`endif

    assign access = accept && mem_op && !misaligned;

    atomrv_lsu_align #(
        .DATAWIDTH (DATAWIDTH)
    ) u_align (
        .rdata      (bus.dccm_rdata_i),
        .sdata      (bus.ex_sdata_i),
        .offset     (offset),
        .size       (size),
        .sign_ext   (load_is_signed(bus.ex_funct3_i)),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // WRITE owns the port; otherwise loads and sub-word stores read, SW writes directly.
    always_comb begin
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wdata    = bus.ex_sdata_i;
        acc_widx = ex_widx;
        if (rst_ni) begin
            if (state_q == WRITE) begin
                wr_en    = 1'b1;
                wdata    = merge_q;
                acc_widx = waddr_q;
            end else if (access) begin
                if (bus.ex_load_i || sub_store) rd_en = 1'b1;
                else                            wr_en = 1'b1;
            end
        end
    end

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.dccm_rd_en_o = rd_en;
    assign bus.dccm_wr_en_o = wr_en;
    assign bus.dccm_wdata_o = wdata;
    assign bus.dccm_addr_o  = {{(DATAWIDTH-ADDRESS_BUS-2){1'b0}}, acc_widx, 2'b00};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            merge_q     <= '0;
            waddr_q     <= '0;
            wb_rwr_en_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            wb_rwr_en_q <= 1'b0;
            if (state_q == WRITE) begin
                state_q <= IDLE;
            end else if (access && sub_store) begin
                state_q <= WRITE;
                merge_q <= merge_data;
                waddr_q <= ex_widx;
            end
            if (accept) begin
                if (!mem_op) begin
                    wb_rwr_en_q <= bus.ex_rwr_en_i;
                    wb_rd_q     <= bus.ex_rd_i;
                    wb_data_q   <= bus.ex_alu_i;
                end else if (bus.ex_load_i && !misaligned) begin
                    wb_rwr_en_q <= bus.ex_rwr_en_i;
                    wb_rd_q     <= bus.ex_rd_i;
                    wb_data_q   <= load_data;
                end
            end
        end
    end

    assign bus.wb_rwr_en_o = wb_rwr_en_q;
    assign bus.wb_rd_o     = wb_rd_q;
    assign bus.wb_data_o   = wb_data_q;
endmodule
